// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the data-RAM controller: bus widths, access sizes,
// controller states and the alignment rule used by the lane aligner.
package ram_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_LANES = XLEN / 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Halves must be 2-byte aligned, words 4-byte aligned; SIZE_X always faults.
    function automatic logic align_fault(input size_e size, input logic [1:0] offset);
        logic f;
        case (size)
            SIZE_B:  f = 1'b0;
            SIZE_H:  f = offset[0];
            SIZE_W:  f = (offset != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the right-aligned pipeline data and a 32-bit
// memory word: store replication + byte mask, load extraction + extension.
module mem_lane_align
    import ram_ctrl_pkg::*;
(
    input  logic [1:0]           offset,
    input  size_e                size,
    input  logic                 uns,
    input  logic [XLEN-1:0]      wdata,
    input  logic [XLEN-1:0]      rword,
    output logic [XLEN-1:0]      wlane,
    output logic [NUM_LANES-1:0] byte_en,
    output logic [XLEN-1:0]      load_data,
    output logic                 align_err
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted   = rword >> {offset, 3'b000};
        wlane     = '0;
        byte_en   = '0;
        load_data = '0;
        align_err = align_fault(size, offset);
        // Store data is replicated across lanes so the mask alone picks the target bytes.
        case (size)
            SIZE_B: begin
                wlane     = {4{wdata[7:0]}};
                byte_en   = 4'b0001 << offset;
                load_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wlane     = {2{wdata[15:0]}};
                byte_en   = 4'b0011 << offset;
                load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                wlane     = wdata;
                byte_en   = 4'b1111;
                load_data = rword;
            end
            default: ;
        endcase
        if (align_err) begin
            byte_en = '0;
        end
    end

endmodule

// File: rtl/ram_ctrl.sv
// Wait-stated data RAM controller for the execute stage: IDLE -> WAIT -> RESP
// handshake with hold_o stall, byte/half/word access and fault reporting.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        hold_o
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic        uns_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    size_e       size_reg;
    logic        ack_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    logic        accept;
    logic        enter_resp;
    logic        eff_we;
    logic        eff_uns;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    size_e       eff_size;
    logic        range_err;
    logic        align_err;
    logic        fault;
    logic        commit;
    logic [IDX_W-1:0]     word_idx;
    logic [XLEN-1:0]      rd_word;
    logic [XLEN-1:0]      wlane;
    logic [XLEN-1:0]      load_data;
    logic [NUM_LANES-1:0] byte_en;

    assign accept = (state_reg == IDLE) && req_i;

    // With no wait states the access completes on the accepting edge, so the
    // live inputs are used while idle and the latched copy afterwards.
    assign eff_we    = (state_reg == IDLE) ? we_i           : we_reg;
    assign eff_uns   = (state_reg == IDLE) ? unsigned_i     : uns_reg;
    assign eff_addr  = (state_reg == IDLE) ? addr_i         : addr_reg;
    assign eff_wdata = (state_reg == IDLE) ? wdata_i        : wdata_reg;
    assign eff_size  = (state_reg == IDLE) ? size_e'(size_i) : size_reg;

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state_reg == WAIT) && (cnt_reg == 4'd0));

    assign range_err = {2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign fault     = range_err || align_err;
    assign commit    = enter_resp && eff_we && !fault && !rst;
    assign word_idx  = eff_addr[IDX_W+1:2];

    assign hold_o  = accept || (state_reg == WAIT);
    assign ack_o   = ack_reg;
    assign err_o   = err_reg;
    assign rdata_o = rdata_reg;

    mem_lane_align u_align (
        .offset    (eff_addr[1:0]),
        .size      (eff_size),
        .uns       (eff_uns),
        .wdata     (eff_wdata),
        .rword     (rd_word),
        .wlane     (wlane),
        .byte_en   (byte_en),
        .load_data (load_data),
        .align_err (align_err)
    );

    // One byte-wide bank per lane gives the per-byte write enable; contents survive reset.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_bank
        logic [7:0] bank [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (commit && byte_en[gi]) begin
                bank[word_idx] <= wlane[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = bank[word_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= SIZE_B;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            if (enter_resp) begin
                ack_reg   <= 1'b1;
                err_reg   <= fault;
                rdata_reg <= (eff_we || fault) ? '0 : load_data;
            end
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        we_reg    <= we_i;
                        uns_reg   <= unsigned_i;
                        addr_reg  <= addr_i;
                        wdata_reg <= wdata_i;
                        size_reg  <= size_e'(size_i);
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait states per access (0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req_i  input  1  the execute stage requests an access.
REQ-007 SHALL have port we_i  input  1  1=store, 0=load.
REQ-008 SHALL have port addr_i  input  32  byte address.
REQ-009 SHALL have port wdata_i  input  32  store data, right-aligned.
REQ-010 SHALL have port size_i  input  2  access size: 00=byte, 01=half, 10=word, 11=illegal.
REQ-011 SHALL have port unsigned_i  input  1  zero-extend load when 1, sign-extend when 0.
REQ-012 SHALL have port rdata_o  output  32  load data, right-aligned and extended; drives the execute stage mem_data_i.
REQ-013 SHALL have port ack_o  output  1  one-cycle access-complete pulse.
REQ-014 SHALL have port err_o  output  1  access faulted; valid only with ack_o.
REQ-015 SHALL have port hold_o  output  1  pipeline stall request.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL, in IDLE with req_i=1, latch we_i, addr_i, wdata_i, size_i and unsigned_i, then go to WAIT, or to RESP directly when WAIT_CYCLES=0.
REQ-018 SHALL count WAIT_CYCLES cycles in WAIT with a down-counter, then enter RESP.
REQ-019 SHALL assert ack_o for exactly the one RESP cycle, then return to IDLE; latency is WAIT_CYCLES+1 cycles from acceptance to ack_o.
REQ-020 SHALL drive hold_o combinationally high in IDLE&&req_i and throughout WAIT, and low in RESP, so the pipeline advances in the ack cycle.
REQ-021 SHALL ignore req_i in WAIT and RESP; back-to-back requests are accepted at the earliest in the cycle after RESP.
REQ-022 SHALL select the byte lane with addr[1:0]; a store writes only the addressed lanes (byte: 1, half: 2, word: 4) from wdata_i[7:0], [15:0] or [31:0].
REQ-023 SHALL commit a store on the clock edge that enters RESP; no other edge writes.
REQ-024 SHALL, for loads, extract the addressed lanes and sign- or zero-extend them per unsigned_i; rdata_o is registered, valid during RESP, and 0 otherwise.
REQ-025 SHALL flag err_o=1 with ack_o for: half with addr[0]=1; word with addr[1:0]!=0; size_i=11; or addr[31:2] >= DEPTH_WORDS.
REQ-026 SHALL, on a fault, suppress the write and return rdata_o=0.
REQ-027 SHALL keep word index addr[31:2] modulo-free: out-of-range is an error, never a wrap-around.

Reset
REQ-028 SHALL, on rst, asynchronously force state=IDLE, counter=0, ack_o=0, err_o=0 and rdata_o=0; hold_o then follows REQ-020.
REQ-029 SHALL abort any access in progress on reset mid-operation, with no store committed and no ack_o issued.
REQ-030 SHALL NOT reset storage contents.

Structure
REQ-031 SHALL place the size encodings (SIZE_B, SIZE_H, SIZE_W) and FSM state encodings in the shared defines file with the core bus-width macros.
REQ-032 SHALL use one combinational sub-module, mem_lane_align, for lane steering and the store byte-mask, and for load extraction and extension.
REQ-033 SHALL infer storage as a DEPTH_WORDS x 32 array with a per-byte write enable.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=1; store word 0xDEADBEEF @0x10, then load word @0x10 -> ack_o 2 cycles after each acceptance, rdata_o=0xDEADBEEF, hold_o high 2 cycles per access.
REQ-035 SHALL cover: store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-036 SHALL cover: load half @0x11 -> err_o=1 with ack_o, rdata_o=0; store word @0x12 -> err_o=1, memory word @0x10 unchanged.
REQ-037 SHALL cover: addr=DEPTH_WORDS*4 -> err_o=1; addr=DEPTH_WORDS*4-4 word -> err_o=0.
REQ-038 SHALL cover: rst asserted in WAIT of a store 0x12345678 @0x20 -> no ack_o; a subsequent load @0x20 returns the prior contents.
REQ-039 SHALL cover: WAIT_CYCLES=0, req_i held high for 4 cycles -> ack_o every second cycle, never in consecutive cycles.
